// File: rtl/vec_mac_pkg.sv
// Shared width helpers and pipeline sideband type for the vec_mac_acc dot-product engine.
package vec_mac_pkg;

    // Product width: one extra bit holds an unsigned product in signed form.
    function automatic int calc_w_p(input int w_x, input int w_k);
        return w_x + w_k + 1;
    endfunction

    function automatic int calc_w_y(input int w_p, input int c, input int acc_bits);
        return w_p + $clog2(c) + acc_bits;
    endfunction

    // Accept of a last beat to m_valid: product stage, tree levels, accumulate stage.
    function automatic int calc_latency(input int c);
        return $clog2(c) + 2;
    endfunction

    typedef struct packed {
        logic valid;
        logic last;
    } sb_t;

endpackage

// File: rtl/vec_mac_acc_add_tree.sv
// Registered signed binary reduction tree: N inputs, one register level per halving step.
module add_tree #(
    parameter  int N     = 16,
    parameter  int W_IN  = 17,
    localparam int LVL   = $clog2(N),
    localparam int W_OUT = W_IN + LVL
) (
    input  logic                    clk,
    input  logic                    i_en,
    input  logic [N*W_IN-1:0]       i_data,
    output logic signed [W_OUT-1:0] o_sum
);

    logic signed [W_OUT-1:0] w_leaf [N];
    // Nodes are held at the final width; level l only ever needs W_IN+l of those bits.
    logic signed [W_OUT-1:0] r_lvl  [1:LVL][N/2];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_leaf[i] = W_OUT'($signed(i_data[i*W_IN +: W_IN]));
        end
    end

    // NOTE: tree data carries no reset; the sideband valid bits in the parent decide what is real.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int j = 0; j < N/2; j++) begin
                r_lvl[1][j] <= w_leaf[2*j] + w_leaf[2*j+1];
            end
            for (int l = 2; l <= LVL; l++) begin
                for (int j = 0; j < N/4; j++) begin
                    if (j < (N >> l)) begin
                        r_lvl[l][j] <= r_lvl[l-1][2*j] + r_lvl[l-1][2*j+1];
                    end
                end
            end
        end
    end

    assign o_sum = r_lvl[LVL][0];

endmodule

// File: rtl/vec_mac_acc.sv
// C-lane dot-product engine: per-beat products, registered adder tree, multi-beat accumulator
// with a valid/ready result port and a global stall driven by downstream backpressure.
module vec_mac_acc
    import vec_mac_pkg::*;
#(
    parameter  int C        = 16,
    parameter  int W_X      = 8,
    parameter  int W_K      = 8,
    parameter  int ACC_BITS = 8,
    localparam int W_P      = calc_w_p(W_X, W_K),
    localparam int W_Y      = calc_w_y(W_P, C, ACC_BITS),
    localparam int LATENCY  = calc_latency(C)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic                  s_signed,
    input  logic [C*W_X-1:0]      x,
    input  logic [C*W_K-1:0]      k,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [W_Y-1:0] y,
    output logic [ACC_BITS:0]     m_beats
);

    localparam int LVL  = $clog2(C);
    localparam int W_T  = W_P + LVL;
    localparam int N_SB = LATENCY - 1;

    function automatic logic signed [W_P-1:0] ext_x(input logic [W_X-1:0] v, input logic sg);
        return sg ? W_P'($signed(v)) : W_P'(v);
    endfunction

    function automatic logic signed [W_P-1:0] ext_k(input logic [W_K-1:0] v, input logic sg);
        return sg ? W_P'($signed(v)) : W_P'(v);
    endfunction

    logic                  w_en;
    logic                  w_accept;
    logic [C*W_P-1:0]      w_prod;
    logic [C*W_P-1:0]      r_prod;
    logic signed [W_T-1:0] w_tree_sum;
    sb_t                   r_sb [N_SB];
    logic signed [W_Y-1:0] r_acc;
    logic signed [W_Y-1:0] w_acc_base;
    logic signed [W_Y-1:0] w_acc_next;
    logic                  r_first;
    logic [ACC_BITS:0]     r_count;
    logic                  r_m_valid;
    logic signed [W_Y-1:0] r_y;
    logic [ACC_BITS:0]     r_m_beats;

    // Whole pipeline freezes only while a result is waiting on a stalled consumer.
    assign w_en     = !r_m_valid || m_ready;
    assign s_ready  = w_en && rstn;
    assign w_accept = s_valid && s_ready;

    // NOTE: combinational blocks assign every output on every path so no latch is inferred.
    always_comb begin
        w_prod = '0;
        for (int c = 0; c < C; c++) begin
            w_prod[c*W_P +: W_P] = ext_x(x[c*W_X +: W_X], s_signed) * ext_k(k[c*W_K +: W_K], s_signed);
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_prod <= w_prod;
        end
    end

    add_tree #(.N(C), .W_IN(W_P)) u_tree (
        .clk    (clk),
        .i_en   (w_en),
        .i_data (r_prod),
        .o_sum  (w_tree_sum)
    );

    // Sideband travels beside the tree: index 0 pairs with r_prod, N_SB-1 with w_tree_sum.
    // NOTE: sequential state uses non-blocking assignments so every stage reads pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N_SB; i++) begin
                r_sb[i] <= '0;
            end
        end else if (w_en) begin
            r_sb[0] <= sb_t'{valid: w_accept, last: s_last};
            for (int i = 1; i < N_SB; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    assign w_acc_base = r_first ? '0 : r_acc;
    assign w_acc_next = w_acc_base + W_Y'(w_tree_sum);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc     <= '0;
            r_first   <= 1'b1;
            r_count   <= '0;
            r_m_valid <= 1'b0;
            r_y       <= '0;
            r_m_beats <= '0;
        end else if (w_en) begin
            // w_en with m_valid high means the current result is taken on this edge.
            r_m_valid <= 1'b0;
            if (r_sb[N_SB-1].valid) begin
                if (r_sb[N_SB-1].last) begin
                    r_y       <= w_acc_next;
                    r_m_beats <= r_count + 1'b1;
                    r_m_valid <= 1'b1;
                    r_first   <= 1'b1;
                    r_count   <= '0;
                end else begin
                    r_acc     <= w_acc_next;
                    r_first   <= 1'b0;
                    r_count   <= r_count + 1'b1;
                end
            end
        end
    end

    assign m_valid = r_m_valid;
    assign y       = r_y;
    assign m_beats = r_m_beats;

endmodule

// File: tb/tb_vec_mac_acc.sv
// Directed bench for vec_mac_acc: table of single-beat results plus multi-beat, stall,
// reset-abort, long-accumulation and randomised accumulation sequences.
module tb_vec_mac_acc;

    localparam int C        = 16;
    localparam int W_X      = 8;
    localparam int W_K      = 8;
    localparam int ACC_BITS = 8;
    localparam int W_Y      = 8 + 8 + 1 + 4 + 8;
    localparam int LAT      = 6;

    logic                  clk;
    logic                  rstn;
    logic                  s_valid;
    logic                  s_ready;
    logic                  s_last;
    logic                  s_signed;
    logic [C*W_X-1:0]      x;
    logic [C*W_K-1:0]      k;
    logic                  m_valid;
    logic                  m_ready;
    logic signed [W_Y-1:0] y;
    logic [ACC_BITS:0]     m_beats;

    vec_mac_acc #(.C(C), .W_X(W_X), .W_K(W_K), .ACC_BITS(ACC_BITS)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .s_signed (s_signed),
        .x        (x),
        .k        (k),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .y        (y),
        .m_beats  (m_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [W_Y-1:0] y;
        logic [ACC_BITS:0]     beats;
    } res_t;

    typedef struct {
        string       name;
        logic [7:0]  xl;
        logic [7:0]  kl;
        bit          sg;
        longint      ey;
    } vec_t;

    res_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Results are captured on the negedge before the handshake edge.
    always @(negedge clk) begin
        if (m_valid && m_ready) q.push_back('{y: y, beats: m_beats});
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [C*W_X-1:0] rep(input logic [7:0] v);
        return {C{v}};
    endfunction

    task automatic send_beat(input logic [C*W_X-1:0] xv, input logic [C*W_K-1:0] kv,
                             input bit sg, input bit last);
        int n;
        bit acc;
        x = xv; k = kv; s_signed = sg; s_last = last; s_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic get_result(input string name, input longint ey, input longint eb);
        int   n;
        res_t r;
        n = 0;
        while (q.size() == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() == 0) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            r = q.pop_front();
            check({name, "_y"}, r.y, ey);
            check({name, "_beats"}, r.beats, eb);
        end
    endtask

    task automatic wait_mvalid(output int n);
        n = 0;
        while (!m_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        vec_t             tbl[$];
        int               n;
        logic [C*W_X-1:0] xv;
        logic [C*W_K-1:0] kv;
        bit               sg;
        longint           ref_sum;
        int               nb;

        tbl = '{
            '{"ff02_s",  8'hFF, 8'h02, 1'b1, -32},
            '{"ff02_u",  8'hFF, 8'h02, 1'b0, 8160},
            '{"8080_s",  8'h80, 8'h80, 1'b1, 262144},
            '{"8080_u",  8'h80, 8'h80, 1'b0, 262144},
            '{"ffff_u",  8'hFF, 8'hFF, 1'b0, 1040400},
            '{"ffff_s",  8'hFF, 8'hFF, 1'b1, 16},
            '{"7f80_s",  8'h7F, 8'h80, 1'b1, -260096},
            '{"7f80_u",  8'h7F, 8'h80, 1'b0, 260096},
            '{"zero_s",  8'h00, 8'h93, 1'b1, 0}
        };

        rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_signed = 1'b0;
        x = '0; k = '0; m_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_y", y, 0);
        check("rst_m_beats", m_beats, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // First result and latency: m_valid rises on the edge LAT-1 after the accept edge
        send_beat(rep(8'h01), rep(8'h01), 1'b1, 1'b1);
        idle();
        wait_mvalid(n);
        check("latency_edges", n, LAT - 1);
        get_result("ones", 16, 1);

        foreach (tbl[i]) begin
            send_beat(rep(tbl[i].xl), rep(tbl[i].kl), tbl[i].sg, 1'b1);
            idle();
            get_result(tbl[i].name, tbl[i].ey, 1);
        end

        // Three-beat accumulation, no result before the last beat
        send_beat(rep(8'h02), rep(8'h03), 1'b1, 1'b0);
        send_beat(rep(8'h02), rep(8'h03), 1'b1, 1'b0);
        idle();
        repeat (10) @(posedge clk); #1;
        check("mb_no_early", q.size() + int'(m_valid), 0);
        send_beat(rep(8'h02), rep(8'h03), 1'b1, 1'b1);
        idle();
        get_result("mb3", 288, 3);

        // Mixed sign modes within one accumulation: -32 + 8160
        send_beat(rep(8'hFF), rep(8'h02), 1'b1, 1'b0);
        send_beat(rep(8'hFF), rep(8'h02), 1'b0, 1'b1);
        idle();
        get_result("mixed", 8128, 2);

        // Back-to-back results into a stalled consumer
        m_ready = 1'b0;
        send_beat(rep(8'h01), rep(8'h01), 1'b1, 1'b1);
        send_beat(rep(8'h02), rep(8'h01), 1'b1, 1'b1);
        send_beat(rep(8'h03), rep(8'h01), 1'b1, 1'b1);
        idle();
        wait_mvalid(n);
        @(negedge clk);
        check("bp_s_ready_low", s_ready, 0);
        check("bp_head_y", y, 16);
        x = rep(8'h04); k = rep(8'h01); s_signed = 1'b1; s_last = 1'b1; s_valid = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_hold_y", y, 16);
        check("bp_hold_beats", m_beats, 1);
        check("bp_hold_s_ready", s_ready, 0);
        check("bp_no_xfer", q.size(), 0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        send_beat(rep(8'h04), rep(8'h01), 1'b1, 1'b1);
        idle();
        get_result("bp_r1", 16, 1);
        get_result("bp_r2", 32, 1);
        get_result("bp_r3", 48, 1);
        get_result("bp_r4", 64, 1);

        // Reset in the middle of an accumulation discards the partial sum
        send_beat(rep(8'h01), rep(8'h01), 1'b1, 1'b0);
        send_beat(rep(8'h01), rep(8'h01), 1'b1, 1'b0);
        idle();
        repeat (2) @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        send_beat(rep(8'h01), rep(8'h01), 1'b1, 1'b1);
        idle();
        get_result("abort_fresh", 16, 1);
        repeat (10) @(posedge clk); #1;
        check("abort_no_extra", q.size(), 0);

        // 256 signed beats at the most negative operand values
        for (int i = 0; i < 256; i++) begin
            send_beat(rep(8'h80), rep(8'h80), 1'b1, i == 255);
        end
        idle();
        get_result("long256", 67108864, 256);

        // Randomised accumulations against a lane-by-lane reference sum
        for (int t = 0; t < 8; t++) begin
            nb = $urandom_range(1, 4);
            ref_sum = 0;
            for (int b = 0; b < nb; b++) begin
                sg = 1'($urandom);
                for (int c = 0; c < C; c++) begin
                    xv[c*W_X +: W_X] = 8'($urandom);
                    kv[c*W_K +: W_K] = 8'($urandom);
                    if (sg) ref_sum += longint'($signed(xv[c*W_X +: W_X])) * longint'($signed(kv[c*W_K +: W_K]));
                    else    ref_sum += longint'(xv[c*W_X +: W_X]) * longint'(kv[c*W_K +: W_K]);
                end
                send_beat(xv, kv, sg, b == nb - 1);
                if ($urandom_range(0, 1) == 1) begin
                    idle();
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            idle();
            get_result($sformatf("rand%0d", t), ref_sum, nb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
